puzzle_grid_core: RTL and testbench
===================================

PUZZLE_GRID_CORE -- requirements
Module: puzzle_grid_core

Interface
REQ-001 SHALL have parameter GRID_N, default 4: board is GRID_N x GRID_N cells, legal range 2..8.
REQ-002 SHALL have parameter STATE_W, default 2: each cell holds 2^STATE_W states.
REQ-003 SHALL have parameter SCRAMBLE_MOVES, default 16: minimum number of random moves per scramble, legal range 1..255.
REQ-004 SHALL have port clk, input, 1, the single clock for all state.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port fire, input, 1, debounced move request, level.
REQ-007 SHALL have port sel, input, GRID_N, one-hot row or column select.
REQ-008 SHALL have port is_col, input, 1: 0 selects a row, 1 selects a column.
REQ-009 SHALL have port add_n, input, 1: 1 increments the selected cells, 0 decrements them.
REQ-010 SHALL have port scramble_start, input, 1, single-cycle pulse.
REQ-011 SHALL have port board_state, output, GRID_N*GRID_N*STATE_W, cell (r,c) at bits [(r*GRID_N+c)*STATE_W +: STATE_W].
REQ-012 SHALL have port error, output, 1, combinational, high when sel is not one-hot.
REQ-013 SHALL have port busy, output, 1, high in SCRAMBLE.
REQ-014 SHALL have port win, output, 1, high in WON.
REQ-015 SHALL have port move_count, output, 16, player moves since the last scramble.

Function
REQ-016 SHALL implement FSM states IDLE, SCRAMBLE, PLAY and WON.
REQ-017 SHALL apply these transitions: IDLE->SCRAMBLE on scramble_start; SCRAMBLE->PLAY when the done rule (REQ-021) holds; PLAY->WON when the registered all-zero flag is set; PLAY/WON->SCRAMBLE on scramble_start.
REQ-018 SHALL detect a fire rising edge internally: the edge is seen at clock edge k when fire=1 and its previous sample was 0.
REQ-019 SHALL, in PLAY only, apply a move for an edge seen at edge k when error=0.
REQ-020 A move SHALL add or subtract 1, modulo 2^STATE_W, on every cell of the selected line; the new board_state is visible after edge k+1.
REQ-021 In SCRAMBLE, SHALL apply one increment move per cycle, taken from the LFSR: bit0 gives is_col, bits[3:1] mod GRID_N give the index; done when the move count is >= SCRAMBLE_MOVES and the board is not all zero.
REQ-022 SHALL ignore fire in IDLE, SCRAMBLE and WON; SHALL ignore scramble_start while in SCRAMBLE.
REQ-023 SHALL assert win one cycle after the move that produced an all-zero board, i.e. after edge k+2.
REQ-024 SHALL increment move_count by 1 per applied player move, saturating at 16'hFFFF, and SHALL clear it to 0 on entry to SCRAMBLE.
REQ-025 SHALL advance the 16-bit Galois LFSR (x^16+x^14+x^13+x^11) every cycle in all states.
REQ-026 When scramble_start coincides with a fire edge in PLAY, scramble_start SHALL win and no player move is applied.

Reset
REQ-027 While reset=0: state=IDLE, every cell=0, board_state=0, busy=0, win=0, move_count=0, LFSR=16'hACE1, fire history=0.
REQ-028 Reset asserted mid-scramble or mid-move SHALL abort the operation immediately, with no partial update kept.

Configuration
REQ-029 With MOVE_COUNTER_EN defined, move_count SHALL behave per REQ-024; without it, move_count SHALL be tied to 0 and no counter logic generated.

Structure
REQ-030 Package puzzle_pkg SHALL hold the FSM state enum, the LFSR seed and taps constants, and the move-count width.
REQ-031 SHALL instantiate one sub-module, puzzle_lfsr (clk, reset, out[15:0]); all other logic is local.

Verification
REQ-032 Reset then idle: board_state=0, win=0, busy=0; a fire edge in IDLE leaves board_state=0.
REQ-033 scramble_start with defaults: busy high for >=16 cycles, then state=PLAY, board nonzero, move_count=0.
REQ-034 From a forced-zero board in PLAY, fire a row-0 increment: cells (0,0..3)=1, others 0, move_count=1; then fire a row-0 decrement: board=0, win=1 two cycles later, move_count=2.
REQ-035 sel=4'b0011 with a fire edge: error=1, board and move_count unchanged; sel=0 gives the same result.
REQ-036 GRID_N=5, STATE_W=3: eight increments of column 4 return the column to 0 (wrap-around); reset asserted during SCRAMBLE gives IDLE with an all-zero board.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared types and constants for the puzzle grid core: FSM states, LFSR seed/taps
// and counter widths.
package puzzle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SCRAMBLE = 2'd1,
    ST_PLAY     = 2'd2,
    ST_WON      = 2'd3
  } state_t;

  // Galois right-shift form of x^16+x^14+x^13+x^11+1 (bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int MOVE_CNT_W = 16;
  localparam int SCR_CNT_W  = 8;

endpackage

// File: rtl/puzzle_lfsr.sv
// Free-running 16-bit Galois LFSR, reloaded with the seed while reset is low.
module puzzle_lfsr
  import puzzle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] out
);

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;

  // Shift right; the bit falling out of bit 0 is folded back in at every tap.
  for (genvar gi = 0; gi < 16; gi++) begin : g_bit
    if (gi == 15) begin : g_top
      assign lfsr_next[gi] = LFSR_TAPS[gi] & lfsr_reg[0];
    end else begin : g_mid
      assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_TAPS[gi] & lfsr_reg[0]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign out = lfsr_reg;

endmodule

// File: rtl/puzzle_grid_core.sv
// Modular row/column shift puzzle with LFSR scrambler and win detection.
// Define MOVE_COUNTER_EN to build the player move counter; otherwise move_count is 0.
module puzzle_grid_core
  import puzzle_pkg::*;
#(
  parameter int GRID_N         = 4,
  parameter int STATE_W        = 2,
  parameter int SCRAMBLE_MOVES = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fire,
  input  logic [GRID_N-1:0]                sel,
  input  logic                             is_col,
  input  logic                             add_n,
  input  logic                             scramble_start,
  output logic [GRID_N*GRID_N*STATE_W-1:0] board_state,
  output logic                             error,
  output logic                             busy,
  output logic                             win,
  output logic [MOVE_CNT_W-1:0]            move_count
);

  localparam int                   CELLS      = GRID_N * GRID_N;
  localparam int                   BOARD_W    = CELLS * STATE_W;
  localparam logic [SCR_CNT_W-1:0] SCR_TARGET = SCR_CNT_W'(SCRAMBLE_MOVES);
  localparam logic [STATE_W-1:0]   CELL_ONE   = STATE_W'(1);

  state_t               state_reg;
  state_t               state_next;
  logic [15:0]          lfsr_out;
  logic                 lfsr_unused;
  logic                 fire_prev_reg;
  logic                 fire_edge;
  logic                 pend_reg;
  logic                 pend_col_reg;
  logic                 pend_dec_reg;
  logic [GRID_N-1:0]    pend_mask_reg;
  logic [SCR_CNT_W-1:0] scr_cnt_reg;
  logic [BOARD_W-1:0]   board_reg;
  logic [BOARD_W-1:0]   board_next;
  logic                 zero_reg;
  logic                 accept_move;
  logic                 play_apply;
  logic                 scr_move;
  logic                 scr_enter;
  logic [GRID_N-1:0]    scr_mask;
  logic [GRID_N-1:0]    mv_mask;
  logic                 mv_en;
  logic                 mv_col;
  logic                 mv_dec;

  puzzle_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr_out)
  );

  assign lfsr_unused = ^lfsr_out[15:4];

  assign error     = (sel == '0) || ((sel & (sel - GRID_N'(1))) != '0);
  assign fire_edge = fire & ~fire_prev_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A fire edge is only captured here; the board changes one edge later.
  always_comb begin
    state_next  = state_reg;
    busy        = 1'b0;
    win         = 1'b0;
    accept_move = 1'b0;
    play_apply  = 1'b0;
    scr_move    = 1'b0;
    scr_enter   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (scramble_start) begin
          state_next = ST_SCRAMBLE;
          scr_enter  = 1'b1;
        end
      end
      ST_SCRAMBLE: begin
        busy = 1'b1;
        if ((scr_cnt_reg >= SCR_TARGET) && !zero_reg) begin
          state_next = ST_PLAY;
        end else begin
          scr_move = 1'b1;
        end
      end
      ST_PLAY: begin
        if (scramble_start) begin
          state_next = ST_SCRAMBLE;
          scr_enter  = 1'b1;
        end else begin
          play_apply = pend_reg;
          if (zero_reg) begin
            state_next = ST_WON;
          end else begin
            accept_move = fire_edge && !error;
          end
        end
      end
      ST_WON: begin
        win = 1'b1;
        if (scramble_start) begin
          state_next = ST_SCRAMBLE;
          scr_enter  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fire_prev_reg <= 1'b0;
      pend_reg      <= 1'b0;
      pend_col_reg  <= 1'b0;
      pend_dec_reg  <= 1'b0;
      pend_mask_reg <= '0;
    end else begin
      fire_prev_reg <= fire;
      pend_reg      <= accept_move;
      if (accept_move) begin
        pend_col_reg  <= is_col;
        pend_dec_reg  <= ~add_n;
        pend_mask_reg <= sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scr_cnt_reg <= '0;
    end else if (scr_enter) begin
      scr_cnt_reg <= '0;
    end else if (scr_move && (scr_cnt_reg != '1)) begin
      scr_cnt_reg <= scr_cnt_reg + SCR_CNT_W'(1);
    end
  end

  // Scrambler line index is LFSR bits [3:1] folded onto the grid size.
  for (genvar gi = 0; gi < GRID_N; gi++) begin : g_scr_mask
    assign scr_mask[gi] = ((32'(lfsr_out[3:1]) % GRID_N) == gi);
  end

  assign mv_en   = scr_move | play_apply;
  assign mv_col  = scr_move ? lfsr_out[0] : pend_col_reg;
  assign mv_dec  = scr_move ? 1'b0 : pend_dec_reg;
  assign mv_mask = scr_move ? scr_mask : pend_mask_reg;

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
    localparam int ROW = gi / GRID_N;
    localparam int COL = gi % GRID_N;
    logic               hit;
    logic [STATE_W-1:0] cur;
    assign cur = board_reg[gi*STATE_W +: STATE_W];
    assign hit = mv_en && (mv_col ? mv_mask[COL] : mv_mask[ROW]);
    assign board_next[gi*STATE_W +: STATE_W] =
      !hit ? cur : (mv_dec ? cur - CELL_ONE : cur + CELL_ONE);
  end

  // zero_reg always mirrors board_reg, so the FSM sees the flag of the current board.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board_reg <= '0;
      zero_reg  <= 1'b1;
    end else begin
      board_reg <= board_next;
      zero_reg  <= (board_next == '0);
    end
  end

  assign board_state = board_reg;

`ifdef MOVE_COUNTER_EN
  logic [MOVE_CNT_W-1:0] move_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      move_cnt_reg <= '0;
    end else if (scr_enter) begin
      move_cnt_reg <= '0;
    end else if (play_apply && (move_cnt_reg != '1)) begin
      move_cnt_reg <= move_cnt_reg + MOVE_CNT_W'(1);
    end
  end

  assign move_count = move_cnt_reg;
`else
  assign move_count = '0;
`endif

endmodule

// File: tb/tb_puzzle_grid_core.sv
// Testbench for puzzle_grid_core: 4x4/2-bit and 5x5/3-bit instances against a
// behavioural model of the board, scrambler and game states.
module tb_puzzle_grid_core;

  localparam int SM = 16;
`ifdef MOVE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst4 = 1'b0;
  logic        rst5 = 1'b0;
  logic        fire = 1'b0;
  logic        is_col = 1'b0;
  logic        add_n = 1'b0;
  logic        scramble_start = 1'b0;
  logic [7:0]  sel_v = 8'h00;

  logic [31:0] bs4;
  logic        err4, busy4, win4;
  logic [15:0] mc4;
  logic [74:0] bs5;
  logic        err5, busy5, win5;
  logic [15:0] mc5;

  int ec4, ec5;
  int total = 0;
  int bad = 0;

  // Model: grid size, bits per cell, modulus, cells, game state (0 idle,1 scr,2 play,3 won).
  int mn = 4;
  int mw = 2;
  int mm = 4;
  int mb [8][8];
  int mstate = 0;
  int mcnt = 0;

  always #5 clk = ~clk;

  puzzle_grid_core dut4 (
    .clk(clk), .reset(rst4), .fire(fire), .sel(sel_v[3:0]), .is_col(is_col),
    .add_n(add_n), .scramble_start(scramble_start), .board_state(bs4),
    .error(err4), .busy(busy4), .win(win4), .move_count(mc4)
  );

  puzzle_grid_core #(.GRID_N(5), .STATE_W(3)) dut5 (
    .clk(clk), .reset(rst5), .fire(fire), .sel(sel_v[4:0]), .is_col(is_col),
    .add_n(add_n), .scramble_start(scramble_start), .board_state(bs5),
    .error(err5), .busy(busy5), .win(win5), .move_count(mc5)
  );

  always @(posedge clk or negedge rst4) if (!rst4) ec4 <= 0; else ec4 <= ec4 + 1;
  always @(posedge clk or negedge rst5) if (!rst5) ec5 <= 0; else ec5 <= ec5 + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] obs_board(); return (mn == 4) ? 128'(bs4) : 128'(bs5); endfunction
  function automatic logic obs_busy(); return (mn == 4) ? busy4 : busy5; endfunction
  function automatic logic obs_win();  return (mn == 4) ? win4 : win5; endfunction
  function automatic logic obs_err();  return (mn == 4) ? err4 : err5; endfunction
  function automatic logic [15:0] obs_mc(); return (mn == 4) ? mc4 : mc5; endfunction
  function automatic int ec(); return (mn == 4) ? ec4 : ec5; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] v = 16'hACE1;
    for (int i = 0; i < n; i++) v = lfsr_adv(v);
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mb[r][c] = 0;
    mstate = 0;
    mcnt = 0;
  endtask

  function automatic bit model_zero();
    for (int r = 0; r < mn; r++) for (int c = 0; c < mn; c++) if (mb[r][c] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [127:0] model_pack();
    logic [127:0] v = '0;
    for (int r = 0; r < mn; r++)
      for (int c = 0; c < mn; c++)
        v = v | (128'(mb[r][c]) << ((r * mn + c) * mw));
    return v;
  endfunction

  task automatic model_line(input bit col, input int idx, input bit dec);
    for (int k = 0; k < mn; k++) begin
      if (col) mb[k][idx] = (mb[k][idx] + (dec ? mm - 1 : 1)) % mm;
      else     mb[idx][k] = (mb[idx][k] + (dec ? mm - 1 : 1)) % mm;
    end
  endtask

  // Scramble: one increment per cycle from the LFSR value present in that cycle,
  // stopping once SM moves are done and the board is not all zero.
  task automatic model_scramble(input int s, output int busy_n);
    logic [15:0] v = lfsr_at(s);
    int j = 0;
    while (!((j >= SM) && !model_zero())) begin
      model_line(v[0], int'(v[3:1]) % mn, 1'b0);
      v = lfsr_adv(v);
      j++;
    end
    busy_n = j + 1;
    mcnt = 0;
    mstate = 2;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_board"}, obs_board(), model_pack());
    check({tag, "_busy"}, 128'(obs_busy()), 128'(mstate == 1));
    check({tag, "_win"}, 128'(obs_win()), 128'(mstate == 3));
    check({tag, "_count"}, 128'(obs_mc()), CNT_EN ? 128'(mcnt) : 128'(0));
  endtask

  task automatic scramble(input bit with_fire, input int restart_at);
    int s, exp_n, n;
    scramble_start = 1'b1;
    fire = with_fire;
    tick();
    scramble_start = 1'b0;
    fire = 1'b0;
    s = ec();
    model_scramble(s, exp_n);
    n = 0;
    while (obs_busy() && n < 2000) begin
      n++;
      if (n == restart_at) scramble_start = 1'b1;
      tick();
      scramble_start = 1'b0;
    end
    $display("scramble start_edge=%0d busy_cycles=%0d expected=%0d", s, n, exp_n);
    check("scr_busy_len", 128'(n), 128'(exp_n));
    check("scr_busy_min", 128'(n > SM), 128'(1));
    check_all("scr_done");
  endtask

  task automatic do_move(input logic [7:0] s, input bit col, input bit add);
    int ones = 0;
    int idx = 0;
    bit oh;
    for (int k = 0; k < mn; k++) if (s[k]) begin ones++; idx = k; end
    oh = (ones == 1);
    sel_v = s;
    is_col = col;
    add_n = add;
    fire = 1'b1;
    tick();
    check("move_error", 128'(obs_err()), 128'(!oh));
    fire = 1'b0;
    tick();
    if (mstate == 2 && oh) begin
      model_line(col, idx, !add);
      if (mcnt < 65535) mcnt++;
    end
    $display("move sel=%0h col=%0d add=%0d board=%0h win=%0d", s, col, add, obs_board(), obs_win());
    check_all("move_k1");
    tick();
    if (mstate == 2 && model_zero()) mstate = 3;
    check("move_k2_win", 128'(obs_win()), 128'(mstate == 3));
  endtask

  initial begin
    logic [127:0] saved;
    logic [7:0] s;
    int a [8];
    int b [8];
    int d [8][8];
    bit solved;
    int pick;

    model_reset();
    repeat (3) tick();
    check_all("reset_hold");
    rst4 = 1'b1;
    tick();
    check_all("idle");
    do_move(8'h01, 1'b0, 1'b1);

    scramble(1'b0, 3);

    for (int i = 0; i < 10; i++) begin
      pick = $urandom_range(0, 5);
      if (pick == 0)      s = 8'h00;
      else if (pick == 1) s = 8'h03;
      else                s = 8'(1 << $urandom_range(0, 3));
      do_move(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    do_move(8'h03, 1'b0, 1'b1);
    do_move(8'h00, 1'b1, 1'b0);

    // Drive the board to "row 0 all ones" by decrementing each line by its offset.
    solved = 1'b0;
    for (int at = 0; at < 4 && !solved; at++) begin
      if (mstate != 2) scramble(1'b0, -1);
      for (int r = 0; r < mn; r++)
        for (int c = 0; c < mn; c++)
          d[r][c] = (mb[r][c] - ((r == 0) ? 1 : 0) + mm) % mm;
      for (int c = 0; c < mn; c++) b[c] = d[0][c];
      for (int r = 0; r < mn; r++) a[r] = (d[r][0] - d[0][0] + mm) % mm;
      for (int c = 0; c < mn; c++) for (int k = 0; k < b[c]; k++) do_move(8'(1 << c), 1'b1, 1'b0);
      for (int r = 1; r < mn; r++) for (int k = 0; k < a[r]; k++) do_move(8'(1 << r), 1'b0, 1'b0);
      solved = (mstate == 2);
    end
    if (solved) begin
      check("target_row0", obs_board(), 128'h55);
      do_move(8'h01, 1'b0, 1'b0);
      check("solved_zero", obs_board(), 128'h0);
      check("solved_win", 128'(obs_win()), 128'(1));
    end
    do_move(8'h01, 1'b0, 1'b1);

    scramble(1'b0, -1);
    scramble(1'b1, 4);

    // Second instance: 5x5 board with 3-bit cells.
    rst4 = 1'b0;
    mn = 5; mw = 3; mm = 8;
    model_reset();
    sel_v = 8'h00;
    rst5 = 1'b1;
    tick();
    check_all("idle5");
    scramble_start = 1'b1;
    tick();
    scramble_start = 1'b0;
    repeat (4) tick();
    check("busy5_mid", 128'(busy5), 128'(1));
    #1 rst5 = 1'b0;
    #1;
    model_reset();
    check_all("reset5_abort");
    tick();
    rst5 = 1'b1;
    tick();
    check_all("idle5_after");
    scramble(1'b0, -1);
    saved = model_pack();
    for (int i = 0; i < 8; i++) do_move(8'h10, 1'b1, 1'b1);
    if (mstate == 2) check("wrap5", obs_board(), saved);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
